// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: load-use stall, memory freeze and redirect squash sequencer with saturating perf counters
module pipeline_stall_ctrl #(
  parameter int SQUASH_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       r1Num_ID,
  input  logic [2:0]       r2Num_ID,
  input  logic             r1Used_ID,
  input  logic             r2Used_ID,
  input  logic             valid_IDEX,
  input  logic             memRead_IDEX,
  input  logic [2:0]       regWriteNum_IDEX,
  input  logic             redirect_EX,
  input  logic             dmemReq_MEM,
  input  logic             dmemReady,
  input  logic             clrCounters,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             idexWrite,
  output logic             exmemWrite,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             bubble_MEMWB,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] redirectCount
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, SQUASH} state_t;
  localparam logic [2:0] SQ_LOAD = 3'(SQUASH_CYCLES);
  state_t state, state_nx;
  logic [2:0] sq_cnt, sq_cnt_nx;
  logic ret_sq, ret_sq_nx;
  logic mem_busy, lu_haz, redir_acc, stall, squashing;
  always_comb begin
    mem_busy = dmemReq_MEM & ~dmemReady;
    lu_haz = valid_IDEX & memRead_IDEX &
             ((r1Used_ID & (r1Num_ID == regWriteNum_IDEX)) | (r2Used_ID & (r2Num_ID == regWriteNum_IDEX)));
    squashing = state == SQUASH;
    redir_acc = ~mem_busy & redirect_EX;
    stall = ~mem_busy & ~redirect_EX & ~squashing & lu_haz;
    state_nx = state;
    sq_cnt_nx = sq_cnt;
    ret_sq_nx = ret_sq;
    if (mem_busy) begin
      if (state == RUN) begin
        state_nx = MEM_WAIT;
        ret_sq_nx = 1'b0;
      end
    end else if (redirect_EX) begin
      state_nx = (SQUASH_CYCLES != 0) ? SQUASH : RUN;
      sq_cnt_nx = SQ_LOAD;
    end else if (squashing) begin
      sq_cnt_nx = sq_cnt - 3'd1;
      state_nx = (sq_cnt <= 3'd1) ? RUN : SQUASH;
    end else if (state == MEM_WAIT) begin
      state_nx = ret_sq ? SQUASH : RUN;
    end
    pcWrite = rst_n & ~mem_busy & ~stall;
    ifidWrite = pcWrite;
    idexWrite = rst_n & ~mem_busy;
    exmemWrite = idexWrite;
    flush_IFID = ~rst_n | (~mem_busy & (redirect_EX | squashing));
    flush_IDEX = ~rst_n | (~mem_busy & (redirect_EX | squashing)) | stall;
    bubble_MEMWB = ~rst_n | mem_busy;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      sq_cnt <= '0;
      ret_sq <= 1'b0;
      stallCycles <= '0;
      redirectCount <= '0;
    end else begin
      state <= state_nx;
      sq_cnt <= sq_cnt_nx;
      ret_sq <= ret_sq_nx;
      stallCycles <= clrCounters ? '0 : (!pcWrite && !(&stallCycles)) ? stallCycles + CNT_W'(1) : stallCycles;
      redirectCount <= clrCounters ? '0 : (redir_acc && !(&redirectCount)) ? redirectCount + CNT_W'(1) : redirectCount;
    end
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: vector table, corner sequences and randomized model check for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;
  localparam int SQ = 1;
  localparam int MAXC = 65535;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] r1Num_ID, r2Num_ID, regWriteNum_IDEX;
  logic r1Used_ID, r2Used_ID, valid_IDEX, memRead_IDEX, redirect_EX, dmemReq_MEM, dmemReady, clrCounters;
  logic pcWrite, ifidWrite, idexWrite, exmemWrite, flush_IFID, flush_IDEX, bubble_MEMWB;
  logic [15:0] stallCycles, redirectCount;
  logic [6:0] outs;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign outs = {pcWrite, ifidWrite, idexWrite, exmemWrite, flush_IFID, flush_IDEX, bubble_MEMWB};
  pipeline_stall_ctrl #(.SQUASH_CYCLES(SQ), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .r1Num_ID(r1Num_ID), .r2Num_ID(r2Num_ID), .r1Used_ID(r1Used_ID),
    .r2Used_ID(r2Used_ID), .valid_IDEX(valid_IDEX), .memRead_IDEX(memRead_IDEX),
    .regWriteNum_IDEX(regWriteNum_IDEX), .redirect_EX(redirect_EX), .dmemReq_MEM(dmemReq_MEM),
    .dmemReady(dmemReady), .clrCounters(clrCounters), .pcWrite(pcWrite), .ifidWrite(ifidWrite),
    .idexWrite(idexWrite), .exmemWrite(exmemWrite), .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
    .bubble_MEMWB(bubble_MEMWB), .stallCycles(stallCycles), .redirectCount(redirectCount)
  );
  typedef struct {
    logic [2:0] r1, r2, wd;
    logic u1, u2, v, mr, rd, rq, ry;
    logic [6:0] e;
    int st, rc;
  } vec_t;
  vec_t tbl[24];
  function automatic vec_t mk(logic [2:0] r1, logic [2:0] r2, logic u1, logic u2, logic v, logic mr,
                              logic [2:0] wd, logic rd, logic rq, logic ry, logic [6:0] e, int st, int rc);
    vec_t t;
    t.r1 = r1; t.r2 = r2; t.u1 = u1; t.u2 = u2; t.v = v; t.mr = mr; t.wd = wd;
    t.rd = rd; t.rq = rq; t.ry = ry; t.e = e; t.st = st; t.rc = rc;
    return t;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(vec_t t);
    r1Num_ID = t.r1; r2Num_ID = t.r2; r1Used_ID = t.u1; r2Used_ID = t.u2;
    valid_IDEX = t.v; memRead_IDEX = t.mr; regWriteNum_IDEX = t.wd;
    redirect_EX = t.rd; dmemReq_MEM = t.rq; dmemReady = t.ry;
  endtask
  task automatic step(string name, vec_t t);
    drive(t);
    @(negedge clk);
    chk({name, ".outs"}, 32'(outs), 32'(t.e));
    chk({name, ".stall_cnt"}, 32'(stallCycles), t.st);
    chk({name, ".redir_cnt"}, 32'(redirectCount), t.rc);
    @(posedge clk);
    #1;
  endtask
  initial begin
    vec_t idle, haz;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1111000, 0, 0);
    haz = mk(3, 0, 1, 0, 1, 1, 3, 0, 0, 0, 7'b0011010, 0, 0);
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1111000, 0, 0);
    tbl[1]  = mk(0, 3, 0, 1, 1, 1, 3, 0, 0, 0, 7'b0011010, 0, 0);
    tbl[2]  = mk(0, 3, 0, 1, 0, 0, 3, 0, 0, 0, 7'b1111000, 1, 0);
    tbl[3]  = mk(3, 5, 0, 1, 1, 1, 3, 0, 0, 0, 7'b1111000, 1, 0);
    tbl[4]  = mk(3, 0, 1, 0, 1, 0, 3, 0, 0, 0, 7'b1111000, 1, 0);
    tbl[5]  = mk(3, 0, 1, 0, 1, 1, 3, 0, 1, 0, 7'b0000001, 1, 0);
    tbl[6]  = mk(3, 0, 1, 0, 1, 1, 3, 0, 1, 0, 7'b0000001, 2, 0);
    tbl[7]  = mk(3, 0, 1, 0, 1, 1, 3, 0, 1, 0, 7'b0000001, 3, 0);
    tbl[8]  = mk(3, 0, 1, 0, 1, 1, 3, 0, 1, 1, 7'b0011010, 4, 0);
    tbl[9]  = mk(3, 0, 1, 0, 0, 0, 3, 0, 0, 0, 7'b1111000, 5, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b1111110, 5, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1111110, 5, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1111000, 5, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b1111110, 5, 1);
    tbl[14] = mk(3, 0, 1, 0, 1, 1, 3, 0, 0, 0, 7'b1111110, 5, 2);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1111000, 5, 2);
    tbl[16] = mk(3, 0, 1, 0, 1, 1, 3, 1, 0, 0, 7'b1111110, 5, 2);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1111110, 5, 3);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1111000, 5, 3);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7'b0000001, 5, 3);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7'b0000001, 6, 3);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7'b1111110, 7, 3);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1111110, 7, 4);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1111000, 7, 4);
    clrCounters = 1'b0;
    drive(idle);
    #3;
    chk("reset.outs", 32'(outs), 32'b0000111);
    chk("reset.stall_cnt", 32'(stallCycles), 0);
    chk("reset.redir_cnt", 32'(redirectCount), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 24; i++) step($sformatf("vec%0d", i), tbl[i]);
    step("pre_reset_redirect", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b1111110, 7, 4));
    drive(idle);
    #2;
    redirect_EX = 1'b1;
    dmemReq_MEM = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_squash_reset.outs", 32'(outs), 32'b0000111);
    chk("mid_squash_reset.stall_cnt", 32'(stallCycles), 0);
    chk("mid_squash_reset.redir_cnt", 32'(redirectCount), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("after_reset0", idle);
    step("after_reset1", idle);
    drive(haz);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat.pre", 32'(stallCycles), 32'hFFFE);
    chk("sat.stalling", 32'(outs), 32'b0011010);
    repeat (3) @(posedge clk);
    #1;
    chk("sat.hold", 32'(stallCycles), 32'hFFFF);
    clrCounters = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_over_inc", 32'(stallCycles), 0);
    clrCounters = 1'b0;
    @(posedge clk);
    #1;
    chk("inc_after_clr", 32'(stallCycles), 1);
    drive(idle);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    begin
      int m_sq, m_st, m_rc;
      bit busy, hz, squashing, take, stl, pc;
      logic [6:0] e;
      m_sq = 0; m_st = 0; m_rc = 0;
      for (int n = 0; n < 3000; n++) begin
        rst_n = ($urandom_range(0, 199) != 0);
        r1Num_ID = 3'($urandom_range(0, 3));
        r2Num_ID = 3'($urandom_range(0, 3));
        regWriteNum_IDEX = 3'($urandom_range(0, 3));
        r1Used_ID = ($urandom_range(0, 3) != 0);
        r2Used_ID = ($urandom_range(0, 1) != 0);
        valid_IDEX = ($urandom_range(0, 3) != 0);
        memRead_IDEX = ($urandom_range(0, 1) != 0);
        redirect_EX = ($urandom_range(0, 7) == 0);
        dmemReq_MEM = ($urandom_range(0, 3) == 0);
        dmemReady = ($urandom_range(0, 1) != 0);
        clrCounters = ($urandom_range(0, 63) == 0);
        if (!rst_n) begin m_sq = 0; m_st = 0; m_rc = 0; end
        busy = dmemReq_MEM && !dmemReady;
        hz = valid_IDEX && memRead_IDEX &&
             ((r1Used_ID && r1Num_ID == regWriteNum_IDEX) || (r2Used_ID && r2Num_ID == regWriteNum_IDEX));
        squashing = m_sq > 0;
        take = !busy && redirect_EX;
        stl = !busy && !redirect_EX && !squashing && hz;
        pc = !busy && !stl;
        e = !rst_n ? 7'b0000111 :
            {pc, pc, !busy, !busy, take || (!busy && squashing), take || (!busy && squashing) || stl, busy};
        @(negedge clk);
        chk($sformatf("rand%0d.outs", n), 32'(outs), 32'(e));
        chk($sformatf("rand%0d.cnts", n), {stallCycles, redirectCount}, {16'(m_st), 16'(m_rc)});
        if (rst_n) begin
          m_st = clrCounters ? 0 : (pc ? m_st : (m_st < MAXC ? m_st + 1 : MAXC));
          m_rc = clrCounters ? 0 : (take && m_rc < MAXC ? m_rc + 1 : m_rc);
          if (take) m_sq = SQ;
          else if (!busy && squashing) m_sq = m_sq - 1;
        end
        @(posedge clk);
        #1;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
